sevenseg_scan_ctrl: RTL and testbench
=====================================

// Module: sevenseg_scan_ctrl
// PURPOSE
//   Time-multiplexes one shared sevenseg_decoder across NUM_DIGITS common-anode digits
//   of the stopwatch display.
//   - Each refresh slot selects one BCD digit from a packed bus and drives it to the decoder.
//   - Enables that digit's anode after a dead-time blank.
//   - Optionally suppresses leading zeros.
//   - Frame-snapshots the inputs so the counter never tears mid-frame.
// PARAMETERS
//   NUM_DIGITS       4       number of digits scanned (>=2)
//   REFRESH_DIV      100000  clk cycles per digit slot, blank + show (> BLANK_CYCLES)
//   BLANK_CYCLES     1000    dead-time cycles at slot start, all anodes off (>=1)
//   LEAD_ZERO_BLANK  1       1 = blank leading zero digits; 0 = show all digits
// PORTS
//   clk          in   1               system clock
//   rst          in   1               synchronous reset, active-high
//   en           in   1               1 = scan display; 0 = all digits dark
//   digits_bcd   in   4*NUM_DIGITS    packed BCD; digit i = [4i+3:4i], digit 0 = rightmost
//   dp_in        in   NUM_DIGITS      decimal point request per digit, active-high
//   bcd_out      out  4               BCD to sevenseg_decoder; 4'hF = blank
//   an_out       out  NUM_DIGITS      digit anode enables, active-low
//   dp_out       out  1               decimal point segment, active-low
//   digit_idx    out  clog2(NUM_DIGITS)  index of the digit currently selected
//   frame_start  out  1               1-cycle pulse when a new frame begins (snapshot taken)
// BEHAVIOUR
//   Reset (rst=1 at clk edge), all outputs registered:
//     state=IDLE, an_out=all 1, bcd_out=4'hF, dp_out=1, digit_idx=0, frame_start=0,
//     slot counter=0, snapshot=0.
//   States: IDLE, BLANK, SHOW.
//   IDLE:  outputs as reset.
//          en=1 -> next cycle BLANK with digit_idx=0, snapshot<=digits_bcd/dp_in, frame_start=1.
//   BLANK: an_out=all 1. bcd_out/dp_out already hold the current digit's values.
//          Lasts exactly BLANK_CYCLES cycles, then SHOW.
//   SHOW:  an_out[digit_idx]=0, all other bits 1.
//          Lasts exactly REFRESH_DIV-BLANK_CYCLES cycles, then BLANK of the next digit.
//          Next digit is digit_idx+1; N-1 wraps to 0.
//          On the wrap: snapshot reloads and frame_start pulses in the first BLANK cycle.
//   Frame period: NUM_DIGITS*REFRESH_DIV cycles.
//   Counter: clog2(REFRESH_DIV) bits. It resets to 0 on every state change and never
//     free-runs past its terminal count.
//   Digit value sources (both taken from the snapshot only; mid-frame input changes are
//     invisible until the next frame_start):
//     bcd_out = snapshot digit, or 4'hF when blanked.
//     dp_out  = ~snapshot dp.
//   Leading zero rule (LEAD_ZERO_BLANK=1): digit i (i>0) is blanked iff, for every j>=i,
//     digit j==0 and dp j==0. Digit 0 is never blanked.
//   Invalid BCD (>9) is passed through unchanged; the decoder renders it blank.
//   en falls in any state: next cycle IDLE with reset outputs. Anodes never remain on.
//   en rises again: restart from digit 0 with a fresh snapshot.
//   rst mid-slot: reset values on the next edge. rst has priority over en.
//   At no cycle is more than one an_out bit low.
//   An anode never goes low in the same cycle that bcd_out changes.
// TESTING (params NUM_DIGITS=4, REFRESH_DIV=10, BLANK_CYCLES=2)
//   1. rst=1 for 3 cycles, en=1
//      -> an_out=4'b1111, bcd_out=4'hF, dp_out=1, frame_start=0 throughout reset.
//   2. en=1, digits=16'h1234, dp=0
//      -> per slot: 2 cycles an=1111, then 8 cycles with one anode low.
//      -> slot sequence an=1110/bcd=4, 1101/3, 1011/2, 0111/1.
//      -> frame_start every 40 cycles.
//   3. digits=16'h0050, dp=0
//      -> digits 3 and 2 output bcd=F; digit 1 = 5; digit 0 = 0.
//      -> with dp=4'b0100: digit 3 = F, digit 2 = 0 displayed.
//   4. Change digits from 16'h0009 to 16'h0010 during digit 1's SHOW
//      -> remainder of frame still shows 0009; next frame shows 0010.
//   5. Deassert en mid-SHOW
//      -> next cycle an_out=1111, bcd_out=F.
//      -> reassert en: frame_start pulses and digit_idx=0.
//   6. Assert rst mid-BLANK with en=1
//      -> reset outputs next cycle.
//      -> after release, scan restarts at digit 0.
//      -> checker: an_out never has 2+ low bits, and never low during a bcd_out change.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one shared BCD-to-7-segment decoder,
// with a dead-time blank per slot, optional leading-zero blanking and per-frame input snapshots.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS      = 4,
  parameter int REFRESH_DIV     = 100000,
  parameter int BLANK_CYCLES    = 1000,
  parameter int LEAD_ZERO_BLANK = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [4*NUM_DIGITS-1:0]         digits_bcd,
  input  logic [NUM_DIGITS-1:0]           dp_in,
  output logic [3:0]                      bcd_out,
  output logic [NUM_DIGITS-1:0]           an_out,
  output logic                            dp_out,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_start
);

  localparam int IDX_W       = $clog2(NUM_DIGITS);
  localparam int CNT_W       = $clog2(REFRESH_DIV);
  localparam int SHOW_CYCLES = REFRESH_DIV - BLANK_CYCLES;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [4*NUM_DIGITS-1:0] snap_q;
  logic [NUM_DIGITS-1:0]   dp_snap_q;
  logic [3:0]              bcd_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    dp_q;
  logic                    frame_start_q;

  // Digit value as sent to the decoder: 4'hF when it is a leading zero with no decimal point
  // anywhere at or above it. Digit 0 always shows.
  function automatic logic [3:0] disp_bcd(input logic [4*NUM_DIGITS-1:0] d,
                                          input logic [NUM_DIGITS-1:0]   p,
                                          input logic [IDX_W-1:0]        idx);
    logic lead_zero;
    // NOTE: blocking assignments are correct here; this is a local variable of a function.
    lead_zero = (LEAD_ZERO_BLANK != 0) && (idx != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx) && (d[4*j +: 4] != 4'd0 || p[j])) lead_zero = 1'b0;
    end
    return lead_zero ? 4'hF : d[4*idx +: 4];
  endfunction

  // bcd_q/dp_q are loaded when a BLANK slot begins, so they are stable before the anode drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments; the snapshot is reset too so
      // a restart never exposes stale digits.
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_q        <= '0;
      dp_snap_q     <= '0;
      bcd_q         <= 4'hF;
      an_q          <= '1;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else if (!en) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      bcd_q         <= 4'hF;
      an_q          <= '1;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q       <= BLANK;
          cnt_q         <= '0;
          idx_q         <= '0;
          snap_q        <= digits_bcd;
          dp_snap_q     <= dp_in;
          bcd_q         <= disp_bcd(digits_bcd, dp_in, '0);
          dp_q          <= ~dp_in[0];
          an_q          <= '1;
          frame_start_q <= 1'b1;
        end
        BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            an_q    <= ~(NUM_DIGITS'(1) << idx_q);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            an_q    <= '1;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              idx_q         <= '0;
              snap_q        <= digits_bcd;
              dp_snap_q     <= dp_in;
              bcd_q         <= disp_bcd(digits_bcd, dp_in, '0);
              dp_q          <= ~dp_in[0];
              frame_start_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
              bcd_q <= disp_bcd(snap_q, dp_snap_q, idx_q + 1'b1);
              dp_q  <= ~dp_snap_q[idx_q + 1'b1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_out     = bcd_q;
  assign an_out      = an_q;
  assign dp_out      = dp_q;
  assign digit_idx   = idx_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl: a time-based display model queues the expected
// outputs for every clock edge and a negedge monitor compares them against the DUT.
module tb_sevenseg_scan_ctrl;

  localparam int N   = 4;
  localparam int RD  = 10;
  localparam int BC  = 2;
  localparam int LZB = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [4*N-1:0] digits_bcd;
  logic [N-1:0]   dp_in;
  logic [3:0]     bcd_out;
  logic [N-1:0]   an_out;
  logic           dp_out;
  logic [1:0]     digit_idx;
  logic           frame_start;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LEAD_ZERO_BLANK(LZB)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .digits_bcd(digits_bcd), .dp_in(dp_in),
    .bcd_out(bcd_out), .an_out(an_out), .dp_out(dp_out),
    .digit_idx(digit_idx), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [3:0] bcd;
    logic       dp;
    logic [1:0] idx;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: position within the frame as a plain cycle count since frame start.
  bit m_active = 1'b0;
  int m_t      = 0;
  int m_snap[N];
  bit m_sdp[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic load_snapshot();
    for (int j = 0; j < N; j++) begin
      m_snap[j] = int'(digits_bcd[4*j +: 4]);
      m_sdp[j]  = dp_in[j];
    end
  endtask

  // Expected outputs after the next clock edge, given the inputs currently driven.
  task automatic model_push();
    exp_t e;
    int   slot, off;
    bit   blank;
    if (rst || !en) begin
      m_active = 1'b0;
      e.an = 4'hF; e.bcd = 4'hF; e.dp = 1'b1; e.idx = 2'd0; e.fs = 1'b0;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_t      = 0;
        load_snapshot();
      end else begin
        m_t++;
        if (m_t == N * RD) begin
          m_t = 0;
          load_snapshot();
        end
      end
      slot  = m_t / RD;
      off   = m_t % RD;
      blank = (LZB != 0) && (slot > 0);
      for (int j = slot; j < N; j++) if (m_snap[j] != 0 || m_sdp[j]) blank = 1'b0;
      e.bcd = blank ? 4'hF : 4'(m_snap[slot]);
      e.dp  = !m_sdp[slot];
      e.an  = (off < BC) ? 4'hF : ~(4'b0001 << slot);
      e.idx = 2'(slot);
      e.fs  = (m_t == 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_push();
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [4*N-1:0] rand_digits();
    logic [4*N-1:0] d;
    for (int j = 0; j < N; j++)
      d[4*j +: 4] = ($urandom_range(0, 3) < 2) ? 4'd0 : 4'($urandom_range(0, 15));
    return d;
  endfunction

  // Monitor: one queued expectation per edge, plus the anode safety invariants.
  logic [3:0] prev_bcd;
  bit         have_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("an_out",      32'(an_out),      32'(e.an));
      check("bcd_out",     32'(bcd_out),     32'(e.bcd));
      check("dp_out",      32'(dp_out),      32'(e.dp));
      check("digit_idx",   32'(digit_idx),   32'(e.idx));
      check("frame_start", 32'(frame_start), 32'(e.fs));
      check("an_single_low", 32'($countones(~an_out) <= 1), 32'd1);
      if (have_prev)
        check("an_low_on_bcd_change",
              32'((bcd_out !== prev_bcd) && (an_out != 4'hF)), 32'd0);
      prev_bcd  = bcd_out;
      have_prev = 1'b1;
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; digits_bcd = 16'h1234; dp_in = 4'b0000;
    step(3);
    rst = 1'b0;
    step(2 * N * RD);
    digits_bcd = 16'h0050;
    step(N * RD);
    dp_in = 4'b0100;
    step(N * RD);
    // Restart, then change the inputs while digit 1 is being shown.
    dp_in = 4'b0000; digits_bcd = 16'h0009; en = 1'b0;
    step(1);
    en = 1'b1;
    step(15);
    digits_bcd = 16'h0010;
    step(2 * N * RD);
    // Drop enable mid-SHOW, then re-enable.
    step(5);
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(25);
    // Restart and assert reset in the first BLANK cycle of digit 1.
    en = 1'b0;
    step(1);
    en = 1'b1;
    step(11);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(N * RD + 5);
    // Randomised traffic.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 7) == 0) digits_bcd = rand_digits();
      if ($urandom_range(0, 9) == 0) dp_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 149) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0; en = 1'b1;
    step(2);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size() <= 1), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
